// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encoding, default word width and CPOL/CPHA mode constants.
// Used by the slave today and intended for the SPI master as well.
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    localparam int SPI_WIDTH = 8;

    localparam bit CPOL_LOW   = 1'b0;
    localparam bit CPOL_HIGH  = 1'b1;
    localparam bit CPHA_LEAD  = 1'b0;
    localparam bit CPHA_TRAIL = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// 2-flop synchronizer with a third flop for rise/fall detection; edges appear 2 clk after the input moves.
// No backpressure; edges are held off until the pipeline holds real samples after reset.
module spi_sync #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic       s1, s2, s3;
    logic [2:0] vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1  <= RST_VAL;
            s2  <= RST_VAL;
            s3  <= RST_VAL;
            vld <= '0;
        end else begin
            s1  <= din;
            s2  <= s1;
            s3  <= s2;
            vld <= {vld[1:0], 1'b1};
        end
    end

    // Reset values are not real observations: an input already active at reset
    // release must not look like a fresh edge.
    assign sync = s2;
    assign rise = vld[2] & s2 & ~s3;
    assign fall = vld[2] & ~s2 & s3;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, MSB first, any CPOL/CPHA; rx_valid pulses 1 clk after the final sample edge is seen.
// No backpressure: the master owns timing; tx_ready/tx_underrun report TX buffer state.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH,
    parameter bit CPOL  = CPOL_LOW,
    parameter bit CPHA  = CPHA_LEAD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_ready,
    output logic             tx_underrun,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    spi_state_t       state, state_nxt;
    logic [WIDTH-1:0] tx_sr, rx_sr, tx_buf;
    logic [CW-1:0]    bit_cnt;

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .reset(reset), .din(sclk),
        .sync(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .din(cs_n),
        .sync(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .din(mosi),
        .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    logic lead_e, trail_e, sample_e, shift_e;
    logic in_shift, active, enter, word_done, copy;

    assign lead_e    = CPOL ? sclk_fall : sclk_rise;
    assign trail_e   = CPOL ? sclk_rise : sclk_fall;
    assign sample_e  = CPHA ? trail_e : lead_e;
    assign shift_e   = CPHA ? lead_e  : trail_e;

    assign in_shift  = (state == ST_SHIFT);
    assign active    = in_shift && !cs_rise;
    assign enter     = (state == ST_IDLE) && cs_fall;
    assign word_done = active && sample_e && (bit_cnt == LAST);
    assign copy      = enter || word_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cs_rise) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        miso_oe = 1'b0;
        miso    = 1'b0;
        if (in_shift) begin
            miso_oe = 1'b1;
            miso    = tx_sr[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr       <= '0;
            rx_sr       <= '0;
            tx_buf      <= '0;
            bit_cnt     <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            tx_ready    <= 1'b1;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= copy && tx_ready;

            // A freshly copied MSB is already on miso; a shift edge seen while the
            // counter sits at 0 belongs to that first bit and must not shift.
            if (copy)
                tx_sr <= tx_ready ? '0 : tx_buf;
            else if (active && shift_e && (bit_cnt != '0))
                tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};

            if (enter || (in_shift && cs_rise))
                bit_cnt <= '0;
            else if (active && sample_e)
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);

            if (active && sample_e)
                rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};

            if (word_done) begin
                rx_data  <= {rx_sr[WIDTH-2:0], mosi_s};
                rx_valid <= 1'b1;
            end

            // A load in the same cycle as a copy wins: the old buffer went out, the new one waits.
            if (tx_load) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (copy) begin
                tx_ready <= 1'b1;
            end
        end
    end

endmodule
